// File: rtl/str_copy_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : str_copy_pkg
//  Purpose  : Shared types and constants for the string copy controller:
//             FSM state encoding, byte type and default maximum length.
//  Revision : 1.0  initial release
// ============================================================================
package str_copy_pkg;

    // Default maximum string length in bytes (power of two, >= 2)
    localparam int DEFAULT_MAX_LEN = 64;

    typedef logic [7:0] byte_t;

    // Copy controller states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/str_copy_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : str_copy_ctrl
//  Purpose  : Byte-wise string copy controller. Reads each source byte
//             (RD cycle), writes it to the destination on the following
//             cycle (WR), then reports completion with a one-cycle done
//             pulse carrying the number of bytes actually written.
//  Ports    : clk/rst_n        clock, asynchronous active-low reset
//             start_*          request handshake (valid/ready) and length
//             abort            terminate the active copy early
//             src_rd_*         source buffer read port (1-cycle latency)
//             dst_wr_*         destination buffer write port
//             busy/done        status; copied_len/len_clamped valid with done
//             iter_cnt         64-bit lifetime write counter (optional)
//  Config   : define STR_COPY_ITER_CNT_EN to add the iter_cnt output.
//  Revision : 1.0  initial release
// ============================================================================
module str_copy_ctrl
    import str_copy_pkg::*;
#(
    parameter  int MAX_LEN = DEFAULT_MAX_LEN,
    localparam int IDX_W   = $clog2(MAX_LEN),
    localparam int LEN_W   = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [LEN_W-1:0] start_len,
    input  logic             abort,
    output logic             src_rd_en,
    output logic [IDX_W-1:0] src_rd_addr,
    input  byte_t            src_rd_data,
    output logic             dst_wr_en,
    output logic [IDX_W-1:0] dst_wr_addr,
    output byte_t            dst_wr_data,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] copied_len,
    output logic             len_clamped
`ifdef STR_COPY_ITER_CNT_EN
    ,
    output logic [63:0]      iter_cnt
`endif
);

    state_e             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_wr_cnt;
    logic               r_clamped;

    logic               w_accept;
    logic               w_clamp;
    logic [LEN_W-1:0]   w_len_in;
    logic               w_last;

    assign w_accept = (r_state == ST_IDLE) && start_valid;
    assign w_clamp  = start_len > LEN_W'(MAX_LEN);
    assign w_len_in = w_clamp ? LEN_W'(MAX_LEN) : start_len;
    // r_len is never zero while in WR, so r_len-1 cannot underflow here
    assign w_last   = ({1'b0, r_idx} == (r_len - LEN_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_len     <= '0;
            r_wr_cnt  <= '0;
            r_clamped <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_len     <= w_len_in;
                        r_idx     <= '0;
                        r_wr_cnt  <= '0;
                        r_clamped <= w_clamp;
                        r_state   <= (w_len_in == '0) ? ST_DONE : ST_RD;
                    end
                end
                ST_RD: begin
                    // Abort here skips the write for the current index
                    r_state <= abort ? ST_DONE : ST_WR;
                end
                ST_WR: begin
                    // The write in this cycle always lands, abort or not
                    r_wr_cnt <= r_wr_cnt + LEN_W'(1);
                    if (w_last || abort) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= ST_RD;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from state so an asynchronous reset drops
    // every strobe in the same instant it forces IDLE.
    assign start_ready = (r_state == ST_IDLE);
    assign busy        = (r_state == ST_RD) || (r_state == ST_WR);
    assign done        = (r_state == ST_DONE);
    assign src_rd_en   = (r_state == ST_RD);
    assign src_rd_addr = r_idx;
    assign dst_wr_en   = (r_state == ST_WR);
    assign dst_wr_addr = r_idx;
    assign dst_wr_data = (r_state == ST_WR) ? src_rd_data : '0;
    assign copied_len  = r_wr_cnt;
    assign len_clamped = r_clamped;

`ifdef STR_COPY_ITER_CNT_EN
    logic [63:0] r_iter_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iter_cnt <= '0;
        end else if (r_state == ST_WR) begin
            r_iter_cnt <= r_iter_cnt + 64'd1;
        end
    end

    assign iter_cnt = r_iter_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/str_copy_ctrl.md
STR_COPY_CTRL -- requirements
Module: str_copy_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64, maximum string length in bytes (power of two, >= 2).
REQ-002 SHALL have derived localparams IDX_W = $clog2(MAX_LEN) and LEN_W = IDX_W+1.
REQ-003 SHALL have ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  copy request
- start_ready  output  1  controller idle, request accepted on valid&&ready
- start_len  input  LEN_W  source string length in bytes
- abort  input  1  terminate active copy
- src_rd_en  output  1  source buffer read strobe
- src_rd_addr  output  IDX_W  source byte index
- src_rd_data  input  8  source byte, valid one cycle after src_rd_en
- dst_wr_en  output  1  destination write strobe
- dst_wr_addr  output  IDX_W  destination byte index
- dst_wr_data  output  8  destination byte
- busy  output  1  copy in progress
- done  output  1  one-cycle completion pulse
- copied_len  output  LEN_W  bytes written by last copy, valid with done
- len_clamped  output  1  start_len exceeded MAX_LEN, valid with done

Function
REQ-004 SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-005 IDLE: start_ready=1; on accept latch len=min(start_len,MAX_LEN), idx=0; go to DONE if len==0, else RD.
REQ-006 RD: src_rd_en=1, src_rd_addr=idx; next state WR.
REQ-007 WR: dst_wr_en=1, dst_wr_addr=idx, dst_wr_data=src_rd_data; increment written count; go to DONE if idx==len-1, else idx++ and RD.
REQ-008 DONE: done=1 for exactly one cycle, copied_len=written count; next state IDLE.
REQ-009 Latency: len N>0 gives 2N access cycles, done in the (2N+1)th cycle after accept; len 0 gives done in the 1st cycle after accept, with zero src/dst strobes.
REQ-010 start_ready SHALL be 0 outside IDLE; a request is accepted in a cycle only if the FSM is in IDLE that cycle, so back-to-back accept occurs one cycle after done.
REQ-011 busy SHALL be 1 in RD and WR, 0 otherwise.
REQ-012 abort in RD SHALL move to DONE with no write for that idx; abort in WR SHALL complete that write, then go to DONE; copied_len reports actual writes.
REQ-013 abort in IDLE or DONE SHALL be ignored.
REQ-014 start_len>MAX_LEN SHALL clamp to MAX_LEN, with len_clamped=1 during done.
REQ-015 Strobes SHALL never be asserted together; dst_wr_addr SHALL never reach or exceed the latched len.

Reset
REQ-016 Asserting rst_n low SHALL force IDLE immediately, asynchronously, mid-copy included, with no further strobes.
REQ-017 Reset values: start_ready=1; busy, done, src_rd_en, dst_wr_en, len_clamped=0; addresses, dst_wr_data, copied_len=0.

Configuration
REQ-018 Macro STR_COPY_ITER_CNT_EN defined: add output iter_cnt, 64 bits, counting every dst write since reset, reset 0, wrapping modulo 2^64.
REQ-019 Macro undefined: the iter_cnt port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-020 Package str_copy_pkg SHALL hold the FSM state enum, a byte typedef and the default MAX_LEN constant.
REQ-021 The block SHALL be a single module with no sub-module; the index/length counter is inline.

Verification
REQ-022 Source "abcd", len 4, destination prefilled "1234" -> destination "abcd", 4 writes at idx 0..3, done in cycle 9 after accept, copied_len=4.
REQ-023 len 0 -> zero src/dst strobes, done in cycle 1 after accept, copied_len=0.
REQ-024 len 8, abort asserted in the 3rd WR cycle -> writes idx 0..2 only, copied_len=3.
REQ-025 MAX_LEN 64, start_len 100 -> 64 writes, len_clamped=1, copied_len=64.
REQ-026 rst_n low during RD of idx 2 of a len-6 copy -> immediate IDLE, start_ready=1, no write at idx 2.
REQ-027 With STR_COPY_ITER_CNT_EN, copies of len 4, 0 and 3 -> iter_cnt=7.
